// File: rtl/qsched_pkg.sv
// qsched_pkg: shared descriptor type, state encoding and saturating add for the QTU packet scheduler.
package qsched_pkg;
  localparam int WORD_WIDTH = 16;
  typedef struct packed {
    logic [WORD_WIDTH-1:0] src_id;
    logic [WORD_WIDTH-1:0] src_hops;
    logic [WORD_WIDTH-1:0] q_value;
    logic [WORD_WIDTH-1:0] energy;
    logic [WORD_WIDTH-1:0] hops_from_ch;
    logic [WORD_WIDTH-1:0] chosen_ch;
    logic                  i_am_dest;
  } pkt_desc_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, HB_ISSUE, HB_WAIT} qsched_state_t;
  function automatic logic [WORD_WIDTH-1:0] sat_add(input logic [WORD_WIDTH-1:0] a, input logic [WORD_WIDTH-1:0] b);
    logic [WORD_WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[WORD_WIDTH] ? '1 : s[WORD_WIDTH-1:0];
  endfunction
endpackage

// File: rtl/pkt_desc_fifo.sv
// pkt_desc_fifo: synchronous descriptor FIFO with push/pop/flush; push is refused when full.
module pkt_desc_fifo
  import qsched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  pkt_desc_t                din,
  output pkt_desc_t                head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW-1:0] wr, rd;
  pkt_desc_t mem [DEPTH];
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rd];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else if (flush) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
    end else begin
      if (do_push) wr <= wr + 1'b1;
      if (do_pop) rd <= rd + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr] <= din;
  end
endmodule

// File: rtl/qtu_pkt_scheduler.sv
// qtu_pkt_scheduler: issues queued descriptors to QTU_FMB one at a time and inserts heartbeat resets between packets.
// Define QSCHED_STATS_EN to add saturating packet/drop/timeout counters.
module qtu_pkt_scheduler
  import qsched_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int HB_SETTLE  = 40,
  parameter int TIMEOUT    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pkt_valid,
  output logic                  pkt_ready,
  input  pkt_desc_t             pkt_desc,
  input  logic                  hb_req,
  output logic                  qtu_en,
  output logic                  qtu_hb_reset,
  output pkt_desc_t             qtu_desc,
  input  logic                  qtu_done,
  output logic                  busy,
  output logic                  timeout_pulse
`ifdef QSCHED_STATS_EN
  ,
  output logic [WORD_WIDTH-1:0] stat_pkts,
  output logic [WORD_WIDTH-1:0] stat_drops,
  output logic [WORD_WIDTH-1:0] stat_timeouts
`endif
);
  localparam int TMAX = TIMEOUT > HB_SETTLE ? TIMEOUT : HB_SETTLE;
  localparam int TW = $clog2(TMAX + 1);
  qsched_state_t state;
  logic hb_pend, full, empty, push, pop, flush, hb_state;
  logic [TW-1:0] timer;
  logic [$clog2(FIFO_DEPTH):0] count;
  pkt_desc_t head;
  assign hb_state = state == HB_ISSUE || state == HB_WAIT;
  // Ready is forced low during reset so every output reads 0 while rst is held.
  assign pkt_ready = !rst && !full && !hb_state;
  assign push = pkt_valid && pkt_ready;
  assign pop = state == IDLE && !hb_pend && !empty;
  assign flush = state == HB_ISSUE;
  assign busy = state != IDLE || count != '0;
  pkt_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .flush(flush), .din(pkt_desc),
    .head(head), .full(full), .empty(empty), .count(count)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      hb_pend <= 1'b0;
      timer <= '0;
      qtu_en <= 1'b0;
      qtu_hb_reset <= 1'b0;
      timeout_pulse <= 1'b0;
      qtu_desc <= '0;
    end else begin
      hb_pend <= hb_req || (hb_pend && state != HB_ISSUE);
      qtu_en <= 1'b0;
      qtu_hb_reset <= 1'b0;
      timeout_pulse <= 1'b0;
      timer <= timer + 1'b1;
      case (state)
        IDLE:
          if (hb_pend) begin
            state <= HB_ISSUE;
            qtu_hb_reset <= 1'b1;
          end else if (!empty) begin
            state <= ISSUE;
            qtu_en <= 1'b1;
            qtu_desc <= head;
          end
        ISSUE: begin
          state <= WAIT;
          timer <= '0;
        end
        WAIT:
          if (qtu_done) state <= IDLE;
          else if (timer == TW'(TIMEOUT - 1)) begin
            state <= IDLE;
            timeout_pulse <= 1'b1;
          end
        HB_ISSUE: begin
          state <= HB_WAIT;
          timer <= '0;
        end
        HB_WAIT: if (timer == TW'(HB_SETTLE - 1)) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`ifdef QSCHED_STATS_EN
  logic [WORD_WIDTH-1:0] drop_inc;
  // A refused push and a heartbeat flush can land in the same cycle.
  assign drop_inc = WORD_WIDTH'(pkt_valid && !pkt_ready) + (flush ? WORD_WIDTH'(count) : '0);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_pkts <= '0;
      stat_drops <= '0;
      stat_timeouts <= '0;
    end else begin
      if (state == WAIT && qtu_done) stat_pkts <= sat_add(stat_pkts, WORD_WIDTH'(1));
      stat_drops <= sat_add(stat_drops, drop_inc);
      if (timeout_pulse) stat_timeouts <= sat_add(stat_timeouts, WORD_WIDTH'(1));
    end
  end
`endif
endmodule

// File: tb/tb_qtu_pkt_scheduler.sv
// tb_qtu_pkt_scheduler: directed scenarios plus random traffic, checked every cycle against a queue-based model.
module tb_qtu_pkt_scheduler;
  import qsched_pkg::*;
  localparam int DEPTH = 4, SETTLE = 40, TMO = 64;
  localparam int P_IDLE = 0, P_ISS = 1, P_WAIT = 2, P_HBI = 3, P_HBW = 4;
  logic clk = 0, rst = 1, pkt_valid = 0, hb_req = 0, qtu_done = 0;
  logic pkt_ready, qtu_en, qtu_hb_reset, busy, timeout_pulse;
  pkt_desc_t pkt_desc = '0, qtu_desc;
`ifdef QSCHED_STATS_EN
  logic [WORD_WIDTH-1:0] stat_pkts, stat_drops, stat_timeouts;
`endif
  int n_chk = 0, n_fail = 0;
  qtu_pkt_scheduler #(.FIFO_DEPTH(DEPTH), .HB_SETTLE(SETTLE), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_desc(pkt_desc),
    .hb_req(hb_req), .qtu_en(qtu_en), .qtu_hb_reset(qtu_hb_reset), .qtu_desc(qtu_desc),
    .qtu_done(qtu_done), .busy(busy), .timeout_pulse(timeout_pulse)
`ifdef QSCHED_STATS_EN
    , .stat_pkts(stat_pkts), .stat_drops(stat_drops), .stat_timeouts(stat_timeouts)
`endif
  );
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural reference: a descriptor queue plus phase/cycle bookkeeping.
  pkt_desc_t mq[$];
  int ph = P_IDLE, wcnt = 0, m_pkts = 0, m_drops = 0, m_tmo = 0;
  bit pend = 0, m_en = 0, m_hb = 0, m_to = 0;
  pkt_desc_t m_desc = '0;

  task automatic model_step();
    int sz, oph;
    bit rdy, n_en, n_hb, n_to;
    if (rst) begin
      mq.delete();
      ph = P_IDLE; wcnt = 0; pend = 0; m_en = 0; m_hb = 0; m_to = 0; m_desc = '0;
      m_pkts = 0; m_drops = 0; m_tmo = 0;
      return;
    end
    sz = mq.size(); oph = ph;
    rdy = sz < DEPTH && ph != P_HBI && ph != P_HBW;
    n_en = 0; n_hb = 0; n_to = 0;
    if (m_to) m_tmo++;
    if (pkt_valid && !rdy) m_drops++;
    case (ph)
      P_IDLE:
        if (pend) begin ph = P_HBI; n_hb = 1; end
        else if (sz > 0) begin m_desc = mq.pop_front(); ph = P_ISS; n_en = 1; end
      P_ISS: begin ph = P_WAIT; wcnt = 0; end
      P_WAIT:
        if (qtu_done) begin ph = P_IDLE; m_pkts++; end
        else if (wcnt == TMO - 1) begin ph = P_IDLE; n_to = 1; end
        else wcnt++;
      P_HBI: begin m_drops += sz; mq.delete(); ph = P_HBW; wcnt = 0; end
      default: if (wcnt == SETTLE - 1) ph = P_IDLE; else wcnt++;
    endcase
    pend = hb_req || (pend && oph != P_HBI);
    if (pkt_valid && rdy) mq.push_back(pkt_desc);
    m_en = n_en; m_hb = n_hb; m_to = n_to;
  endtask

  task automatic compare();
    chk("en", qtu_en, m_en);
    chk("hb_reset", qtu_hb_reset, m_hb);
    chk("timeout", timeout_pulse, m_to);
    chk("desc", qtu_desc, m_desc);
    chk("busy", busy, ph != P_IDLE || mq.size() != 0);
    chk("ready", pkt_ready, !rst && mq.size() < DEPTH && ph != P_HBI && ph != P_HBW);
`ifdef QSCHED_STATS_EN
    chk("stat_pkts", stat_pkts, 16'(m_pkts));
    chk("stat_drops", stat_drops, 16'(m_drops));
    chk("stat_timeouts", stat_timeouts, 16'(m_tmo));
`endif
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    compare();
  end

  function automatic pkt_desc_t rand_desc();
    pkt_desc_t d;
    d.src_id = 16'($urandom); d.src_hops = 16'($urandom); d.q_value = 16'($urandom);
    d.energy = 16'($urandom); d.hops_from_ch = 16'($urandom); d.chosen_ch = 16'($urandom);
    d.i_am_dest = 1'($urandom_range(0, 1));
    return d;
  endfunction

  function automatic bit sig(input int s);
    return s == 0 ? qtu_en : s == 1 ? qtu_hb_reset : timeout_pulse;
  endfunction

  task automatic wait_sig(input int s, input int lim, input string nm, output int n);
    n = 0;
    while (!sig(s) && n < lim) begin @(negedge clk); n++; end
    chk(nm, sig(s), 1'b1);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_en"}, qtu_en, 1'b0);
    chk({nm, "_hb"}, qtu_hb_reset, 1'b0);
    chk({nm, "_to"}, timeout_pulse, 1'b0);
    chk({nm, "_desc"}, qtu_desc, '0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_ready"}, pkt_ready, 1'b0);
`ifdef QSCHED_STATS_EN
    chk({nm, "_stats"}, {stat_pkts, stat_drops, stat_timeouts}, '0);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1; pkt_valid = 0; hb_req = 0; qtu_done = 0;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, c, fe, ft, ne, nt, rok, r5, p;
    int hbc[$];
    pkt_desc_t d1;
    d1 = '{src_id: 16'd65, src_hops: 16'd2, q_value: 16'h0C00, energy: 16'h3333,
           hops_from_ch: 16'd2, chosen_ch: 16'd25, i_am_dest: 1'b0};
    #1;
    check_zero("por");
    do_reset();
    // single packet, done 4 cycles after en
    @(negedge clk); pkt_valid = 1; pkt_desc = d1;
    @(negedge clk); pkt_valid = 0;
    wait_sig(0, 10, "t1_en", n);
    chk("t1_en_lat", n, 1);
    chk("t1_desc", qtu_desc, d1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t1_en_single", qtu_en, 1'b0);
      chk("t1_desc_stable", qtu_desc, d1);
    end
    qtu_done = 1;
    @(negedge clk); qtu_done = 0;
    chk("t1_idle_busy", busy, 1'b0);
    chk("t1_no_to", timeout_pulse, 1'b0);
`ifdef QSCHED_STATS_EN
    chk("t1_pkts", stat_pkts, 16'd1);
`endif
    // back-to-back pushes until refusal, every packet times out
    do_reset();
    ne = 0; nt = 0; fe = -1; ft = -1; rok = 0; r5 = 1;
    for (c = 0; c < 350; c++) begin
      @(negedge clk);
      if (c < 6) begin
        pkt_valid = 1; pkt_desc = rand_desc();
        if (c < 5) rok += int'(pkt_ready); else r5 = int'(pkt_ready);
      end else pkt_valid = 0;
      if (qtu_en) begin ne++; if (fe < 0) fe = c; end
      if (timeout_pulse) begin nt++; if (ft < 0) ft = c; end
    end
    chk("t2_accepted", rok, 5);
    chk("t2_refused", r5, 0);
    chk("t2_en_count", ne, 5);
    chk("t2_to_count", nt, 5);
    chk("t2_en_to_gap", ft - fe, 65);
`ifdef QSCHED_STATS_EN
    chk("t2_drops", stat_drops, 16'd1);
    chk("t2_timeouts", stat_timeouts, 16'd5);
`endif
    // heartbeat during WAIT is deferred until done, then flushes the queue
    do_reset();
    for (int i = 0; i < 3; i++) begin @(negedge clk); pkt_valid = 1; pkt_desc = rand_desc(); end
    @(negedge clk); pkt_valid = 0; hb_req = 1;
    @(negedge clk); hb_req = 0;
    for (int i = 0; i < 10; i++) begin @(negedge clk); chk("t3_no_hb_mid", qtu_hb_reset, 1'b0); end
    qtu_done = 1;
    @(negedge clk); qtu_done = 0;
    wait_sig(1, 5, "t3_hb", n);
    chk("t3_hb_lat", n, 1);
    c = 0; p = 0;
    while (!pkt_ready && c < 100) begin
      p += int'(qtu_hb_reset);
      c++;
      @(negedge clk);
    end
    chk("t3_ready_low", c, 41);
    chk("t3_hb_width", p, 1);
    chk("t3_flushed", busy, 1'b0);
`ifdef QSCHED_STATS_EN
    chk("t3_drops", stat_drops, 16'd2);
`endif
    // two heartbeats 3 cycles apart
    do_reset();
    hbc.delete();
    for (c = 0; c < 150; c++) begin
      @(negedge clk);
      hb_req = c == 0 || c == 3;
      if (qtu_hb_reset) hbc.push_back(c);
    end
    chk("t4_hb_count", hbc.size(), 2);
    if (hbc.size() == 2) chk("t4_hb_gap", hbc[1] - hbc[0], 42);
    // done on the final WAIT cycle beats the timeout
    do_reset();
    @(negedge clk); pkt_valid = 1; pkt_desc = rand_desc();
    @(negedge clk); pkt_valid = 0;
    wait_sig(0, 10, "t5_en", n);
    repeat (TMO) @(negedge clk);
    qtu_done = 1;
    @(negedge clk); qtu_done = 0;
    nt = 0;
    for (int i = 0; i < 5; i++) begin nt += int'(timeout_pulse); @(negedge clk); end
    chk("t5_no_to", nt, 0);
    chk("t5_idle", busy, 1'b0);
`ifdef QSCHED_STATS_EN
    chk("t5_pkts", stat_pkts, 16'd1);
`endif
    // reset mid-WAIT and mid-HB_WAIT
    do_reset();
    for (int i = 0; i < 3; i++) begin @(negedge clk); pkt_valid = 1; pkt_desc = rand_desc(); end
    @(negedge clk); pkt_valid = 0;
    repeat (5) @(negedge clk);
    rst = 1; #1;
    check_zero("t6_wait");
    repeat (2) @(negedge clk);
    rst = 0;
    ne = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); ne += int'(qtu_en); end
    chk("t6_fifo_empty", ne, 0);
    hb_req = 1;
    @(negedge clk); hb_req = 0;
    wait_sig(1, 5, "t6_hb", n);
    repeat (10) @(negedge clk);
    rst = 1; #1;
    check_zero("t6_hbwait");
    repeat (2) @(negedge clk);
    rst = 0;
    // random traffic against the model
    for (int s = 0; s < 10; s++) begin
      p = s % 3 == 0 ? 0 : s % 3 == 1 ? 3 : 25;
      for (int i = 0; i < 250; i++) begin
        @(negedge clk);
        rst = $urandom_range(0, 999) == 0;
        pkt_valid = $urandom_range(0, 99) < 40;
        pkt_desc = rand_desc();
        hb_req = $urandom_range(0, 199) == 0;
        qtu_done = $urandom_range(0, 99) < p;
      end
    end
    @(negedge clk);
    rst = 0; pkt_valid = 0; hb_req = 0; qtu_done = 0;
    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
